// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc register feeding a 2-entry {pc, instr} FIFO toward decode.
// Redirect clears the FIFO and reloads pc; decode pops with if_valid/if_ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t        occ;
  logic [31:0] pc;
  logic [31:0] head_pc, head_instr;
  logic [31:0] tail_pc, tail_instr;
  logic        pop, push;
  logic        redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign if_valid  = (occ != EMPTY);
  assign if_pc     = head_pc;
  assign if_instr  = head_instr;
  assign imem_addr = pc[9:2];

  assign pop  = if_valid && if_ready;
  assign push = fetch_en && !redirect_valid && ((occ != FULL) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ        <= EMPTY;
      pc         <= RESET_PC;
      head_pc    <= '0;
      head_instr <= '0;
      tail_pc    <= '0;
      tail_instr <= '0;
    end else if (redirect_valid) begin
      occ <= EMPTY;
      pc  <= {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) pc <= pc + 32'd4;
      case (occ)
        EMPTY: begin
          if (push) begin
            head_pc    <= pc;
            head_instr <= imem_data;
            occ        <= ONE;
          end
        end
        ONE: begin
          // With a simultaneous pop the new word replaces the head directly.
          if (push && pop) begin
            head_pc    <= pc;
            head_instr <= imem_data;
          end else if (push) begin
            tail_pc    <= pc;
            tail_instr <= imem_data;
            occ        <= FULL;
          end else if (pop) begin
            occ <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            if (push) begin
              tail_pc    <= pc;
              tail_instr <= imem_data;
            end else begin
              occ <= ONE;
            end
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a queue-based reference model of the fetch FIFO.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [31:0] mem [256];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: queue of {pc, instr} entries and a program counter.
  logic [63:0] mq[$];
  logic [31:0] mpc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [63:0] h;
    check_eq("if_valid", {31'd0, if_valid}, {31'd0, mq.size() != 0});
    check_eq("imem_addr", {24'd0, imem_addr}, {24'd0, mpc[9:2]});
    if (mq.size() != 0) begin
      h = mq[0];
      check_eq("if_pc", if_pc, h[63:32]);
      check_eq("if_instr", if_instr, h[31:0]);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = 32'h0000_0000;
  endtask

  // Applies one cycle of inputs, advances the model, then checks after the edge.
  task automatic step(input logic fen, input logic rdy, input logic rv, input logic [31:0] rpc);
    bit do_pop, do_push;
    fetch_en       = fen;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    do_pop  = (mq.size() != 0) && rdy;
    do_push = fen && !rv && (mq.size() < 2 || do_pop);
    if (rv) begin
      mq.delete();
      mpc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({mpc, mem[mpc[9:2]]});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [31:0] held_pc;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0020_0513;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0025_0233;
    mem[3] = 32'h0041_2223;
    mem[5] = 32'h01F0_0313;

    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_pc", if_pc, 32'd0);
    check_eq("rst_instr", if_instr, 32'd0);
    check_eq("rst_addr", {24'd0, imem_addr}, 32'd0);
    rst_n = 1'b1;

    // Streaming: one instruction per cycle from address 0.
    step(1, 1, 0, 0);
    check_eq("seq_pc0", if_pc, 32'h0);
    check_eq("seq_in0", if_instr, 32'h0020_0513);
    step(1, 1, 0, 0);
    check_eq("seq_pc1", if_pc, 32'h4);
    check_eq("seq_in1", if_instr, 32'h0010_0113);
    step(1, 1, 0, 0);
    check_eq("seq_pc2", if_pc, 32'h8);
    step(1, 1, 0, 0);
    check_eq("seq_pc3", if_pc, 32'hC);
    check_eq("seq_in3", if_instr, 32'h0041_2223);

    // Backpressure: fills, then freezes.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    check_eq("full_addr", {24'd0, imem_addr}, {24'd0, if_pc[9:2] + 8'd2});
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    // Redirect while full to a misaligned target.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0016);
    check_eq("redir_empty", {31'd0, if_valid}, 32'd0);
    step(1, 0, 0, 0);
    check_eq("redir_pc", if_pc, 32'h14);
    check_eq("redir_in", if_instr, 32'h01F0_0313);

    // Word address wrap at the top of the 256-word window.
    step(1, 1, 1, 32'h0000_03FC);
    check_eq("wrap_ff", {24'd0, imem_addr}, 32'hFF);
    step(1, 1, 0, 0);
    check_eq("wrap_00", {24'd0, imem_addr}, 32'h00);
    step(1, 1, 0, 0);
    check_eq("wrap_pc", if_pc, 32'h0000_0400);

    // fetch_en low drains the FIFO and holds pc.
    step(1, 1, 0, 0);
    held_pc = mpc;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check_eq("drain_empty", {31'd0, if_valid}, 32'd0);
    step(1, 1, 0, 0);
    check_eq("resume_pc", if_pc, held_pc);

    // Asynchronous reset while full.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("arst_addr", {24'd0, imem_addr}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0);
    check_eq("arst_restart", if_pc, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(4, 0) > 1,
           $urandom_range(9, 0) == 0, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset (bits [1:0] zero).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port fetch_en  input  1  fetch permitted when high.
REQ-005 SHALL have port imem_addr  output  8  word address to instruction memory, equal to pc[9:2].
REQ-006 SHALL have port imem_data  input  32  combinational memory read data for imem_addr, valid in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port if_valid  output  1  head entry valid toward decode.
REQ-010 SHALL have port if_ready  input  1  decode accepts head entry.
REQ-011 SHALL have port if_instr  output  32  instruction of the head entry.
REQ-012 SHALL have port if_pc  output  32  byte address of the head entry.

Function
REQ-013 SHALL hold a 32-bit pc register and a 2-entry FIFO of {pc, instr}; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-014 SHALL drive imem_addr = pc[9:2] continuously; addresses wrap modulo 256 words, and pc wraps modulo 2^32.
REQ-015 SHALL drive if_valid = (occupancy != 0), and if_instr/if_pc from the head entry, all from registers only.
REQ-016 SHALL define pop = if_valid && if_ready.
REQ-017 SHALL define push = fetch_en && !redirect_valid && (occupancy < 2 || pop).
REQ-018 On push, SHALL write {pc, imem_data} at the FIFO tail and set pc <= pc + 4.
REQ-019 With push and pop in the same cycle, occupancy SHALL be unchanged, and order SHALL be preserved (no drop, no duplicate).
REQ-020 When FULL without pop, SHALL hold pc and imem_addr, and keep if_pc/if_instr stable.
REQ-021 When fetch_en is low, SHALL hold pc while pops continue to drain the FIFO.
REQ-022 On redirect_valid, SHALL take priority: FIFO cleared to EMPTY and pc <= {redirect_pc[31:2], 2'b00}, with no push that cycle.
REQ-023 On redirect_valid coinciding with a pop, SHALL treat the pop as a completed transfer; the FIFO is still cleared.
REQ-024 Latency SHALL be one cycle: an instruction pushed at edge N is visible with if_valid high after edge N, and after a redirect at edge N the target is at the head after edge N+1.
REQ-025 Sustained throughput SHALL be one instruction per cycle with fetch_en=1 and if_ready=1.

Reset
REQ-026 While rst_n is low, SHALL immediately (asynchronously) hold pc=RESET_PC, occupancy=0, if_valid=0, if_instr=0, if_pc=0, imem_addr=RESET_PC[9:2].
REQ-027 Reset asserted mid-operation SHALL discard all FIFO contents regardless of state.
REQ-028 The first push SHALL occur on the first rising edge with rst_n high and fetch_en high.

Verification
REQ-029 Scenario: memory words 0..3 = 00200513, 00100113, 00250233, 00412223; reset released; fetch_en=1 and if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles starting one cycle after release, with matching if_instr.
REQ-030 Scenario: if_ready low for 5 cycles -> FULL after 2 pushes, imem_addr frozen at head+2 words, and if_pc/if_instr stable; on release -> contiguous sequence with no gap or duplicate.
REQ-031 Scenario: redirect_valid with redirect_pc=0x0000_0016 while FULL -> if_valid=0 for one cycle, then if_pc=0x14 and if_instr=01F00313 (word 5).
REQ-032 Scenario: redirect to 0x0000_03FC -> imem_addr=0xFF; on the next push, imem_addr=0x00 and the following if_pc=0x0000_0400.
REQ-033 Scenario: fetch_en deasserted for 3 cycles with FIFO ONE and if_ready=1 -> FIFO drains to EMPTY and pc is held; on re-enable -> fetch resumes at the held pc.
REQ-034 Scenario: rst_n pulsed low between clock edges while FULL -> if_valid=0 before the next edge and imem_addr=RESET_PC[9:2]; after release -> the sequence restarts at 0x0.
